// File: rtl/simulated_aes_decrypt_engine_if.sv
// Block stream between the load path and the decrypt engine.
// The master drives ciphertext; the slave returns plaintext.
interface simulated_aes_decrypt_engine_if;
    logic         next_input;
    logic [127:0] data_in;
    logic         ready_output;
    logic [127:0] data_out;

    modport master (
        output next_input,
        output data_in,
        input  ready_output,
        input  data_out
    );

    modport slave (
        input  next_input,
        input  data_in,
        output ready_output,
        output data_out
    );
endinterface

// File: rtl/simulated_aes_decrypt_engine.sv
// Fixed-latency pipelined stand-in for an AES-128 decrypt core.
// Optional macro SIM_AES_DEC_ZERO_IDLE_EN: data_out reads zero when idle.
module simulated_aes_decrypt_engine #(
    parameter int unsigned  NUM_CYCLE = 4,
    parameter int unsigned  ROT       = 8,
    parameter logic [127:0] KEY       =
        128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0
) (
    input logic clock,
    input logic reset,
    simulated_aes_decrypt_engine_if.slave bus
);

    function automatic logic [127:0] f_rotl(
        input logic [127:0] x,
        input int unsigned  n
    );
        logic [255:0] w_cat;
        w_cat = {x, x} << (n % 128);
        return w_cat[255:128];
    endfunction

    function automatic logic [127:0] f_rotr(
        input logic [127:0] x,
        input int unsigned  n
    );
        logic [255:0] w_cat;
        w_cat = {x, x} >> (n % 128);
        return w_cat[127:0];
    endfunction

    logic [NUM_CYCLE:0] w_v;
    logic [127:0]       w_d [NUM_CYCLE+1];

    assign w_v[0] = bus.next_input;
    assign w_d[0] = bus.data_in;

    genvar j;
    generate
        for (j = 0; j < NUM_CYCLE; j++) begin : g_stage
            // Stage j undoes encrypt round N-1-j.
            localparam logic [127:0] RK =
                f_rotl(KEY, (8 * (NUM_CYCLE - 1 - j)) % 128);

            logic         r_v;
            logic [127:0] r_d;
            logic [127:0] w_x;

            assign w_x = f_rotr(w_d[j] ^ RK, ROT);

            if (j == NUM_CYCLE - 1) begin : g_last
                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_v <= 1'b0;
                        r_d <= '0;
                    end else begin
                        r_v <= w_v[j];
                        if (w_v[j]) begin
                            r_d <= w_x;
                        end
`ifdef SIM_AES_DEC_ZERO_IDLE_EN
                        else begin
                            r_d <= '0;
                        end
`endif
                    end
                end
            end else begin : g_mid
                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_v <= 1'b0;
                    end else begin
                        r_v <= w_v[j];
                    end
                end

                always_ff @(posedge clock) begin
                    r_d <= w_x;
                end
            end

            assign w_v[j+1] = r_v;
            assign w_d[j+1] = r_d;
        end
    endgenerate

    assign bus.ready_output = w_v[NUM_CYCLE];
    assign bus.data_out     = w_d[NUM_CYCLE];

endmodule

// File: tb/tb_simulated_aes_decrypt_engine.sv
// Bench for simulated_aes_decrypt_engine: two instances (default key, zero key)
// checked each cycle against a block-level reference model.
module tb_simulated_aes_decrypt_engine;

    localparam int N   = 4;
    localparam int ROT = 8;
    localparam logic [127:0] KEY_A =
        128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] KEY_B = 128'h0;
    localparam int DEPTH = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    simulated_aes_decrypt_engine_if bus_a ();
    simulated_aes_decrypt_engine_if bus_b ();

    simulated_aes_decrypt_engine #(
        .NUM_CYCLE(N), .ROT(ROT), .KEY(KEY_A)
    ) u_dut_a (
        .clock(clock), .reset(reset), .bus(bus_a.slave)
    );

    simulated_aes_decrypt_engine #(
        .NUM_CYCLE(N), .ROT(ROT), .KEY(KEY_B)
    ) u_dut_b (
        .clock(clock), .reset(reset), .bus(bus_b.slave)
    );

    int compared = 0;
    int mismatched = 0;
    int e = 0;

    bit           in_v [DEPTH];
    logic [127:0] in_d [DEPTH];
    bit           rs   [DEPTH];

    logic [127:0] hold_a = '0;
    logic [127:0] hold_b = '0;

    function automatic logic [127:0] rol(logic [127:0] x, int n);
        int s = n % 128;
        if (s == 0) return x;
        return (x << s) | (x >> (128 - s));
    endfunction

    function automatic logic [127:0] ror(logic [127:0] x, int n);
        int s = n % 128;
        if (s == 0) return x;
        return (x >> s) | (x << (128 - s));
    endfunction

    function automatic logic [127:0] rkey(int i, logic [127:0] k);
        return rol(k, (8 * i) % 128);
    endfunction

    function automatic logic [127:0] enc(logic [127:0] x, logic [127:0] k);
        for (int i = 0; i < N; i++) x = rol(x, ROT) ^ rkey(i, k);
        return x;
    endfunction

    function automatic logic [127:0] dec(logic [127:0] x, logic [127:0] k);
        for (int i = N - 1; i >= 0; i--) x = ror(x ^ rkey(i, k), ROT);
        return x;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s edge=%0d observed=%h expected=%h",
                   tag, e, obs, exp);
        end
    endtask

    task automatic step(bit v, logic [127:0] d, bit r);
        bit exp_rdy;
        int k;
        bus_a.next_input = v;
        bus_a.data_in    = d;
        bus_b.next_input = v;
        bus_b.data_in    = d;
        reset            = r;
        @(posedge clock);
        e++;
        in_v[e] = v && !r;
        in_d[e] = d;
        rs[e]   = r;
        #1;
        exp_rdy = 1'b0;
        k = e - N + 1;
        if (k >= 1 && in_v[k]) begin
            exp_rdy = 1'b1;
            for (int m = k + 1; m <= e; m++) if (rs[m]) exp_rdy = 1'b0;
        end
        if (r) begin
            hold_a = '0;
            hold_b = '0;
        end else if (exp_rdy) begin
            hold_a = dec(in_d[k], KEY_A);
            hold_b = dec(in_d[k], KEY_B);
        end else begin
`ifdef SIM_AES_DEC_ZERO_IDLE_EN
            hold_a = '0;
            hold_b = '0;
`endif
        end
        chk("rdy_a", {127'b0, bus_a.ready_output}, {127'b0, exp_rdy});
        chk("rdy_b", {127'b0, bus_b.ready_output}, {127'b0, exp_rdy});
        chk("data_a", bus_a.data_out, hold_a);
        chk("data_b", bus_b.data_out, hold_b);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] p;
        logic [127:0] exp_b;
        bus_a.next_input = 1'b0;
        bus_a.data_in    = '0;
        bus_b.next_input = 1'b0;
        bus_b.data_in    = '0;

        // reset, then idle
        step(1'b1, '0, 1'b1);
        step(1'b1, rnd128(), 1'b1);
        repeat (10) step(1'b0, '0, 1'b0);

        // single pulse through zero-key instance
        step(1'b1, 128'h1, 1'b0);
        repeat (N - 1) step(1'b0, '0, 1'b0);
        exp_b = 128'h00000001_00000000_00000000_00000000;
        chk("zero_key_rdy", {127'b0, bus_b.ready_output}, 128'h1);
        chk("zero_key_data", bus_b.data_out, exp_b);
        step(1'b0, '0, 1'b0);

        // encrypt then decrypt is identity
        p = 128'h0123456789ABCDEF_FEDCBA9876543210;
        step(1'b1, enc(p, KEY_A), 1'b0);
        repeat (N - 1) step(1'b0, '0, 1'b0);
        chk("roundtrip", bus_a.data_out, p);
        repeat (3) step(1'b0, '0, 1'b0);

        // back-to-back A, B, C
        repeat (3) step(1'b1, rnd128(), 1'b0);
        repeat (N + 2) step(1'b0, '0, 1'b0);

        // reset two edges after capture kills the block
        step(1'b1, rnd128(), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        repeat (N + 2) step(1'b0, '0, 1'b0);

        // gapped inputs at cycles 0, 2, 7
        for (int c = 0; c < 14; c++) begin
            if (c == 0 || c == 2 || c == 7) step(1'b1, rnd128(), 1'b0);
            else step(1'b0, rnd128(), 1'b0);
        end

        // random traffic with occasional reset
        for (int c = 0; c < 300; c++) begin
            step(1'($urandom_range(0, 1)), rnd128(),
                 ($urandom_range(0, 29) == 0));
        end
        repeat (N + 1) step(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
